gol_generation_scheduler: RTL and testbench
===========================================

Name: gol_generation_scheduler

Overview:
- Sequences one Game of Life generation over the 8x16 toroidal cell array held in an external double-banked cell RAM.
- On each generation tick while the game FSM reports RUN, it sweeps every cell and reads self plus 8 neighbours from the current bank. It writes the next state into the shadow bank, then swaps banks.
- It also owns the RAM write port and arbitrates it between itself and program-mode cell edits.

Parameters:
- ROWS, 8, grid rows.
- COLS, 16, grid columns; cell index = row*COLS + col.
- NCELL, 128, ROWS*COLS; index width 7.
- CNTW, 16, width of generation counter.

Ports:
- clka  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- game_state  in  2  FSM state: 00 IDLE, 01 PROGRAM, 10 RUN, 11 PAUSE.
- gen_tick  in  1  single-cycle generation request.
- prgm_we  in  1  program-mode cell write strobe.
- prgm_idx  in  7  program-mode cell index.
- prgm_val  in  1  program-mode cell value.
- mem_raddr  out  8  {bank, idx} read address.
- mem_rdata  in  1  read data, valid the cycle after mem_raddr.
- mem_we  out  1  RAM write enable.
- mem_waddr  out  8  {bank, idx} write address.
- mem_wdata  out  1  RAM write data.
- cur_bank  out  1  bank holding the displayed/current generation.
- cell_idx  out  7  cell currently being evaluated.
- busy  out  1  generation in progress.
- gen_done  out  1  one-cycle pulse in SWAP cycle.
- gen_count  out  CNTW  completed generations, wraps at 2^CNTW.

Behaviour:
- Reset: state IDLE; cur_bank=0, cell_idx=0, gen_count=0, busy=0, gen_done=0, mem_we=0, neighbour count=0. A reset mid-generation discards the sweep; the bank is not swapped.
- States: IDLE, READ, LAST, WRITE, SWAP.
- IDLE -> READ when game_state==10 and gen_tick. Also set cell_idx=0, k=0, busy=1.
- gen_tick is ignored when game_state!=10 and while busy. Ticks are not queued.
- READ (9 cycles, k=0..8):
  - mem_raddr={cur_bank, nbr(cell_idx,k)}.
  - k order: 0 self, then NW, N, NE, W, E, SW, S, SE.
  - Row/col wrap modulo ROWS/COLS: row-1 of 0 is 7; col+1 of 15 is 0.
  - In cycles k>=1, capture mem_rdata of read k-1: k=1 stores self, later reads add to the 4-bit neighbour count.
- LAST: capture the read-8 data. -> WRITE.
- WRITE: mem_we=1, mem_waddr={~cur_bank, cell_idx}, mem_wdata=(n==3)|(self&(n==2)).
  - Clear n. If cell_idx==127 -> SWAP; else cell_idx+1, k=0 -> READ.
- Cell timing: 11 cycles per cell. With the tick sampled at edge 0, cell c occupies cycles 11c+1..11c+11.
- SWAP: cycle 1409. gen_done=1; cur_bank toggles and gen_count increments at the end of the cycle. -> IDLE; busy=0 from cycle 1410.
- game_state changes mid-sweep:
  - 11 (PAUSE) or 01: the sweep completes, including SWAP; generations are atomic.
  - 00 (stop): abort at the next edge to IDLE with no SWAP. cur_bank and gen_count are unchanged; partial shadow writes are harmless.
- Write-port arbitration:
  - When busy, the scheduler owns the port; prgm_we is ignored.
  - When not busy and game_state==01: mem_we=prgm_we, mem_waddr={cur_bank, prgm_idx}, mem_wdata=prgm_val, combinational pass-through.
  - Otherwise mem_we=0.
- When idle: mem_raddr={cur_bank, cell_idx}, cell_idx holds its value; no RAM side effects.
- gen_done never coincides with busy=0.

Test Plan:
- Reset: assert rst 2 cycles mid-sweep -> cur_bank=0, gen_count=0, busy=0, mem_we=0 the cycle after release.
- Blinker:
  - Program idx 52, 53, 54 = 1 in PROGRAM, then RUN with one tick.
  - Expect gen_done in cycle 1409, cur_bank=1, gen_count=1.
  - New bank has exactly 37, 53, 69 live. A second tick restores 52, 53, 54 in bank 0.
- Toroidal wrap: corner block {0, 15, 112, 127} live -> unchanged after 3 generations (still life across the wrap).
- Pause/stop mid-sweep:
  - game_state 10->11 at cycle 500 -> sweep finishes, gen_done at 1409.
  - game_state 10->00 at cycle 500 -> busy=0 at cycle 501, no gen_done, cur_bank unchanged.
- Tick during busy: extra gen_tick at cycle 700 -> exactly one gen_done, gen_count+1 only.
- Arbitration:
  - prgm_we with idx 5 while busy -> no write to idx 5.
  - prgm_we in PROGRAM when idle -> mem_we=1, mem_waddr={cur_bank,5} the same cycle.

Source files
------------

// File: rtl/gol_generation_scheduler.sv
// Game of Life generation sequencer for a double-banked 8x16 toroidal cell RAM.
// Sweeps every cell (self + 8 neighbours), writes the shadow bank, swaps banks, and arbitrates the RAM write port.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a RUN-mode tick; program-mode writes pass through
// S_READ  | 9 cycles, k=0..8: issue self/neighbour reads, capture read k-1
// S_LAST  | capture the final (SE) neighbour read
// S_WRITE | write next state of cell_idx into the shadow bank
// S_SWAP  | flip cur_bank, bump gen_count, pulse gen_done
module gol_generation_scheduler #(
    parameter int ROWS = 8,
    parameter int COLS = 16,
    parameter int CNTW = 16,
    localparam int NCELL = ROWS * COLS,
    localparam int IDXW  = $clog2(NCELL)
) (
    input  logic            clka,
    input  logic            rst,
    input  logic [1:0]      game_state,
    input  logic            gen_tick,
    input  logic            prgm_we,
    input  logic [IDXW-1:0] prgm_idx,
    input  logic            prgm_val,
    output logic [IDXW:0]   mem_raddr,
    input  logic            mem_rdata,
    output logic            mem_we,
    output logic [IDXW:0]   mem_waddr,
    output logic            mem_wdata,
    output logic            cur_bank,
    output logic [IDXW-1:0] cell_idx,
    output logic            busy,
    output logic            gen_done,
    output logic [CNTW-1:0] gen_count
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    localparam logic [1:0] GS_IDLE    = 2'b00;
    localparam logic [1:0] GS_PROGRAM = 2'b01;
    localparam logic [1:0] GS_RUN     = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LAST,
        S_WRITE,
        S_SWAP
    } state_t;

    state_t state, state_nxt;

    logic [3:0] k;
    logic [3:0] nbr_cnt;
    logic       self_q;
    logic       start;
    logic       abort;

    // Grid dimensions are powers of two, so row/col are plain slices of the index.
    logic [RW-1:0] row, row_up, row_dn, nrow;
    logic [CW-1:0] col, col_lf, col_rt, ncol;

    always_comb begin
        row    = cell_idx[IDXW-1:CW];
        col    = cell_idx[CW-1:0];
        row_up = (row == '0) ? RW'(ROWS - 1) : row - RW'(1);
        row_dn = (row == RW'(ROWS - 1)) ? '0 : row + RW'(1);
        col_lf = (col == '0) ? CW'(COLS - 1) : col - CW'(1);
        col_rt = (col == CW'(COLS - 1)) ? '0 : col + CW'(1);

        case (k)
            4'd1, 4'd2, 4'd3: nrow = row_up;
            4'd6, 4'd7, 4'd8: nrow = row_dn;
            default:          nrow = row;
        endcase

        case (k)
            4'd1, 4'd4, 4'd6: ncol = col_lf;
            4'd3, 4'd5, 4'd8: ncol = col_rt;
            default:          ncol = col;
        endcase
    end

    assign start = (state == S_IDLE) && (game_state == GS_RUN) && gen_tick;
    assign abort = (state != S_IDLE) && (game_state == GS_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_READ;
            S_READ:  if (k == 4'd8) state_nxt = S_LAST;
            S_LAST:  state_nxt = S_WRITE;
            S_WRITE: state_nxt = (cell_idx == IDXW'(NCELL - 1)) ? S_SWAP : S_READ;
            S_SWAP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    always_comb begin
        busy      = (state != S_IDLE);
        gen_done  = (state == S_SWAP) && !abort;
        mem_raddr = (state == S_READ) ? {cur_bank, nrow, ncol} : {cur_bank, cell_idx};
        mem_we    = 1'b0;
        mem_waddr = {cur_bank, prgm_idx};
        mem_wdata = prgm_val;
        if (state == S_WRITE) begin
            mem_we    = 1'b1;
            mem_waddr = {~cur_bank, cell_idx};
            mem_wdata = (nbr_cnt == 4'd3) || (self_q && (nbr_cnt == 4'd2));
        end else if (!busy && (game_state == GS_PROGRAM)) begin
            mem_we = prgm_we;
        end
    end

    always_ff @(posedge clka) begin
        if (rst) begin
            state     <= S_IDLE;
            cur_bank  <= 1'b0;
            cell_idx  <= '0;
            gen_count <= '0;
            k         <= '0;
            nbr_cnt   <= '0;
            self_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cell_idx <= '0;
                        k        <= '0;
                        nbr_cnt  <= '0;
                    end
                end
                S_READ: begin
                    // Read data lags the address by one cycle, so cycle k captures read k-1.
                    if (k == 4'd1)
                        self_q <= mem_rdata;
                    else if (k != 4'd0)
                        nbr_cnt <= nbr_cnt + {3'b000, mem_rdata};
                    k <= k + 4'd1;
                end
                S_LAST: begin
                    nbr_cnt <= nbr_cnt + {3'b000, mem_rdata};
                end
                S_WRITE: begin
                    nbr_cnt <= '0;
                    k       <= '0;
                    if (cell_idx != IDXW'(NCELL - 1))
                        cell_idx <= cell_idx + IDXW'(1);
                end
                S_SWAP: begin
                    if (!abort) begin
                        cur_bank  <= ~cur_bank;
                        gen_count <= gen_count + CNTW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gol_generation_scheduler.sv
// Self-checking bench for gol_generation_scheduler: behavioural RAM, plain-arithmetic Life model,
// table-driven write-port arbitration vectors, hand sequences and randomized generations.
module tb_gol_generation_scheduler;

    localparam int ROWS  = 8;
    localparam int COLS  = 16;
    localparam int NCELL = ROWS * COLS;

    logic        clka = 1'b0;
    logic        rst;
    logic [1:0]  game_state;
    logic        gen_tick;
    logic        prgm_we;
    logic [6:0]  prgm_idx;
    logic        prgm_val;
    logic [7:0]  mem_raddr;
    logic        mem_rdata;
    logic        mem_we;
    logic [7:0]  mem_waddr;
    logic        mem_wdata;
    logic        cur_bank;
    logic [6:0]  cell_idx;
    logic        busy;
    logic        gen_done;
    logic [15:0] gen_count;

    always #5 clka = ~clka;

    gol_generation_scheduler dut (
        .clka       (clka),
        .rst        (rst),
        .game_state (game_state),
        .gen_tick   (gen_tick),
        .prgm_we    (prgm_we),
        .prgm_idx   (prgm_idx),
        .prgm_val   (prgm_val),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .cur_bank   (cur_bank),
        .cell_idx   (cell_idx),
        .busy       (busy),
        .gen_done   (gen_done),
        .gen_count  (gen_count)
    );

    // Double-banked cell RAM with one-cycle read latency.
    logic ram [256];
    always @(posedge clka) begin
        if (mem_we) ram[mem_waddr] <= mem_wdata;
        mem_rdata <= ram[mem_raddr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0] exp_grid;
    logic         exp_bank;
    logic [15:0]  exp_count;

    int r_done, r_ndone, r_idle, r_viol;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] life_step(input logic [127:0] g);
        logic [127:0] nx;
        int n;
        nx = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0)
                            n += int'(g[((r + dr + ROWS) % ROWS) * COLS + ((c + dc + COLS) % COLS)]);
                nx[r * COLS + c] = (n == 3) || (g[r * COLS + c] && n == 2);
            end
        end
        return nx;
    endfunction

    function automatic logic [127:0] bank_img(input logic b);
        logic [127:0] v;
        for (int i = 0; i < NCELL; i++) v[i] = ram[{b, 7'(i)}];
        return v;
    endfunction

    task automatic prog_grid(input logic [127:0] g);
        game_state = 2'b01;
        for (int i = 0; i < NCELL; i++) begin
            prgm_we  = 1'b1;
            prgm_idx = 7'(i);
            prgm_val = g[i];
            @(posedge clka); #1;
        end
        prgm_we  = 1'b0;
        exp_grid = g;
    endtask

    // Tick is sampled at edge 0; loop index c is the cycle number after that edge.
    task automatic run_gen(input int chg_at, input logic [1:0] chg_gs, input int tick_at, input int prgm_from);
        r_done = -1; r_ndone = 0; r_idle = -1; r_viol = 0;
        game_state = 2'b10;
        gen_tick   = 1'b1;
        @(posedge clka); #1;
        gen_tick = 1'b0;
        for (int c = 1; c <= 1600; c++) begin
            if (c == chg_at) game_state = chg_gs;
            gen_tick = (c == tick_at);
            if (prgm_from > 0 && c >= prgm_from && c < prgm_from + 20) begin
                prgm_we = 1'b1; prgm_idx = 7'd5; prgm_val = 1'b1;
            end else begin
                prgm_we = 1'b0;
            end
            @(negedge clka);
            if (gen_done) begin
                r_ndone++;
                if (r_done < 0) r_done = c;
                if (!busy) r_viol++;
            end
            if (!busy) begin
                r_idle = c;
                @(posedge clka); #1;
                break;
            end
            @(posedge clka); #1;
        end
        gen_tick = 1'b0;
        prgm_we  = 1'b0;
    endtask

    task automatic do_gen(input string name, input int chg_at, input logic [1:0] chg_gs,
                          input int tick_at, input int prgm_from);
        logic [127:0] old;
        logic         ob;
        old = exp_grid;
        ob  = exp_bank;
        run_gen(chg_at, chg_gs, tick_at, prgm_from);
        exp_grid  = life_step(old);
        exp_bank  = ~ob;
        exp_count = exp_count + 16'd1;
        chk({name, " gen_done cycle"}, 128'(r_done), 128'(1409));
        chk({name, " gen_done pulses"}, 128'(r_ndone), 128'(1));
        chk({name, " idle cycle"}, 128'(r_idle), 128'(1410));
        chk({name, " gen_done without busy"}, 128'(r_viol), 128'(0));
        chk({name, " cur_bank"}, 128'(cur_bank), 128'(exp_bank));
        chk({name, " gen_count"}, 128'(gen_count), 128'(exp_count));
        chk({name, " new bank"}, bank_img(exp_bank), exp_grid);
        chk({name, " old bank"}, bank_img(ob), old);
    endtask

    typedef struct {
        logic [1:0] gs;
        logic       we;
        logic [6:0] idx;
        logic       val;
        logic       exp_we;
        logic       exp_wdata;
    } arb_vec_t;

    arb_vec_t vecs [7];

    initial begin
        logic [127:0] g, corner, vert, horiz;
        logic [1:0]   gs;

        vecs[0] = '{2'b01, 1'b1, 7'd5,   1'b1, 1'b1, 1'b1};
        vecs[1] = '{2'b01, 1'b0, 7'd5,   1'b1, 1'b0, 1'b0};
        vecs[2] = '{2'b00, 1'b1, 7'd9,   1'b1, 1'b0, 1'b0};
        vecs[3] = '{2'b10, 1'b1, 7'd9,   1'b1, 1'b0, 1'b0};
        vecs[4] = '{2'b11, 1'b1, 7'd9,   1'b0, 1'b0, 1'b0};
        vecs[5] = '{2'b01, 1'b1, 7'd127, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{2'b01, 1'b1, 7'd64,  1'b1, 1'b1, 1'b1};

        rst = 1'b1; game_state = 2'b00; gen_tick = 1'b0;
        prgm_we = 1'b0; prgm_idx = '0; prgm_val = 1'b0;
        exp_grid = '0; exp_bank = 1'b0; exp_count = '0;
        repeat (3) @(posedge clka);
        #1 rst = 1'b0;

        @(negedge clka);
        chk("reset cur_bank", 128'(cur_bank), 128'(0));
        chk("reset gen_count", 128'(gen_count), 128'(0));
        chk("reset busy", 128'(busy), 128'(0));
        chk("reset mem_we", 128'(mem_we), 128'(0));
        chk("reset gen_done", 128'(gen_done), 128'(0));
        chk("reset cell_idx", 128'(cell_idx), 128'(0));
        chk("reset mem_raddr", 128'(mem_raddr), 128'(0));
        @(posedge clka); #1;

        foreach (vecs[i]) begin
            game_state = vecs[i].gs;
            prgm_we    = vecs[i].we;
            prgm_idx   = vecs[i].idx;
            prgm_val   = vecs[i].val;
            @(negedge clka);
            chk($sformatf("arb[%0d] mem_we", i), 128'(mem_we), 128'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                chk($sformatf("arb[%0d] mem_waddr", i), 128'(mem_waddr), 128'({exp_bank, vecs[i].idx}));
                chk($sformatf("arb[%0d] mem_wdata", i), 128'(mem_wdata), 128'(vecs[i].exp_wdata));
            end
            @(posedge clka); #1;
        end
        prgm_we = 1'b0;

        // Blinker: horizontal at row 3 cols 4..6 becomes vertical at col 5 rows 2..4.
        g = '0; g[52] = 1'b1; g[53] = 1'b1; g[54] = 1'b1;
        horiz = g;
        vert = '0; vert[37] = 1'b1; vert[53] = 1'b1; vert[69] = 1'b1;
        prog_grid(g);
        do_gen("blinker1", 0, 2'b10, 0, 0);
        chk("blinker1 vertical bank1", bank_img(1'b1), vert);

        // Program-mode pass-through now targets bank 1; rewrite the same value.
        game_state = 2'b01; prgm_we = 1'b1; prgm_idx = 7'd5; prgm_val = exp_grid[5];
        @(negedge clka);
        chk("idle pass mem_we", 128'(mem_we), 128'(1));
        chk("idle pass mem_waddr", 128'(mem_waddr), 128'({1'b1, 7'd5}));
        chk("idle pass mem_wdata", 128'(mem_wdata), 128'(exp_grid[5]));
        @(posedge clka); #1;
        prgm_we = 1'b0;

        do_gen("blinker2", 0, 2'b10, 0, 0);
        chk("blinker2 horizontal bank0", bank_img(1'b0), horiz);

        // Corner block is a still life across both wraps.
        corner = '0; corner[0] = 1'b1; corner[15] = 1'b1; corner[112] = 1'b1; corner[127] = 1'b1;
        prog_grid(corner);
        for (int i = 0; i < 3; i++) do_gen($sformatf("corner%0d", i), 0, 2'b10, 0, 0);
        chk("corner unchanged", bank_img(exp_bank), corner);

        // Pause mid-sweep: generation still completes.
        g = {$urandom, $urandom, $urandom, $urandom};
        prog_grid(g);
        do_gen("pause", 500, 2'b11, 0, 0);

        // Stop mid-sweep: abort without swap.
        g = {$urandom, $urandom, $urandom, $urandom};
        prog_grid(g);
        run_gen(500, 2'b00, 0, 0);
        chk("stop idle cycle", 128'(r_idle), 128'(501));
        chk("stop no gen_done", 128'(r_ndone), 128'(0));
        chk("stop cur_bank", 128'(cur_bank), 128'(exp_bank));
        chk("stop gen_count", 128'(gen_count), 128'(exp_count));
        chk("stop current bank intact", bank_img(exp_bank), exp_grid);

        // Extra tick while busy is dropped.
        do_gen("tick busy", 0, 2'b10, 700, 0);

        // Program writes while busy are ignored; cell 5 starts dead so a leak would show.
        g = {$urandom, $urandom, $urandom, $urandom};
        g[5] = 1'b0;
        prog_grid(g);
        do_gen("prgm busy", 300, 2'b01, 0, 400);

        for (int i = 0; i < 3; i++) begin
            g  = {$urandom, $urandom, $urandom, $urandom};
            gs = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
            prog_grid(g);
            do_gen($sformatf("random%0d", i), int'($urandom_range(2, 1400)), gs,
                   int'($urandom_range(2, 1400)), 0);
        end

        // Reset mid-sweep.
        game_state = 2'b10; gen_tick = 1'b1;
        @(posedge clka); #1;
        gen_tick = 1'b0;
        repeat (300) @(posedge clka);
        #1 rst = 1'b1;
        repeat (2) @(posedge clka);
        #1 rst = 1'b0;
        @(negedge clka);
        chk("midrst cur_bank", 128'(cur_bank), 128'(0));
        chk("midrst gen_count", 128'(gen_count), 128'(0));
        chk("midrst busy", 128'(busy), 128'(0));
        chk("midrst mem_we", 128'(mem_we), 128'(0));
        repeat (3) @(posedge clka);
        @(negedge clka);
        chk("midrst stays idle", 128'(busy), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
